fp_mul_param: RTL and testbench

Parametrised, handshaked IEEE-754 floating-point multiplier. It replaces the fixed single-precision multiplier used in the matrix multiplier datapath. Exponent and mantissa widths are configurable, and it adds:
- full valid/ready flow control on both sides
- four selectable rounding modes
- IEEE exception flags
- an internal iterative shift-add mantissa multiplier, so no external multiplier instance is needed

---
 rtl/fp_mul_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_mul_param.sv
// fp_mul_param: parametrised IEEE-754 multiplier with valid/ready handshake,
// four rounding modes, exception flags and an iterative shift-add mantissa core.
module fp_mul_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [1:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [3:0]             out_flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned M  = MAN_W + 1;
  localparam int unsigned EW = EXP_W + 3;
  localparam int unsigned CW = $clog2(MAN_W + 4);

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMIN  = EW'(2 - (1 << (EXP_W - 1)));
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic [CW-1:0] MUL_LAST = CW'(M - 1);
  // After M+2 shifts every significand, guard and round bit sits in sticky.
  localparam logic [CW-1:0] DEN_MAX  = CW'(M + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StUnpack, StNorm, StMul, StNormOut, StDenorm, StRound, StOut
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]           a_q, b_q;
  logic [1:0]             rm_q;
  logic                   sign_q;
  logic signed [EW-1:0]   a_e_q, b_e_q, exp_q;
  logic [M-1:0]           a_sig_q, b_sig_q, sig_q;
  logic [2*M-1:0]         prod_q;
  logic                   g_q, r_q, s_q, tiny_q;
  logic [CW-1:0]          cnt_q;

  // Operand classification and special-case results.
  logic [EXP_W-1:0]       a_ef, b_ef;
  logic [MAN_W-1:0]       a_fr, b_fr;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                   sign_ab, special;
  logic [W-1:0]           spec_z;
  logic [3:0]             spec_flags;
  logic signed [EW-1:0]   a_e_un, b_e_un;

  // Decode operands and resolve NaN/inf/zero combinations.
  always_comb begin
    a_ef    = a_q[W-2:MAN_W];
    b_ef    = b_q[W-2:MAN_W];
    a_fr    = a_q[MAN_W-1:0];
    b_fr    = b_q[MAN_W-1:0];
    a_nan   = (&a_ef) && (|a_fr);
    b_nan   = (&b_ef) && (|b_fr);
    a_inf   = (&a_ef) && !(|a_fr);
    b_inf   = (&b_ef) && !(|b_fr);
    a_zero  = !(|a_ef) && !(|a_fr);
    b_zero  = !(|b_ef) && !(|b_fr);
    sign_ab = a_q[W-1] ^ b_q[W-1];
    a_e_un  = (a_ef == '0) ? EMIN : $signed({3'b000, a_ef}) - BIAS;
    b_e_un  = (b_ef == '0) ? EMIN : $signed({3'b000, b_ef}) - BIAS;
    special    = 1'b1;
    spec_z     = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_z     = QNAN;
      // Signalling NaN has the fraction MSB clear.
      spec_flags = {(a_nan && !a_fr[MAN_W-1]) || (b_nan && !b_fr[MAN_W-1]), 3'b000};
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_z     = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_z = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_z = {sign_ab, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Datapath helpers: multiply step, product normalisation, rounding and packing.
  logic [M:0]             mul_sum;
  logic [2*M-1:0]         prod_sh;
  logic                   den_go;
  logic                   nx, inc, ovf, to_inf, uf;
  logic [M:0]             rnd_sum;
  logic [M-1:0]           rnd_sig;
  logic signed [EW-1:0]   rnd_exp, rnd_bexp;
  logic [W-1:0]           pack_z;
  logic [3:0]             pack_flags;

  // Combinational arithmetic feeding the datapath registers.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*M-1:M]} + (b_sig_q[0] ? {1'b0, a_sig_q} : '0);
    prod_sh = prod_q[2*M-1] ? prod_q : {prod_q[2*M-2:0], 1'b0};
    den_go  = (exp_q < EMIN) && (cnt_q != DEN_MAX);
    nx      = g_q | r_q | s_q;
    inc     = 1'b0;
    to_inf  = 1'b0;
    unique case (rm_q)
      2'b00: begin inc = g_q && (r_q || s_q || sig_q[0]); to_inf = 1'b1;    end
      2'b01: begin inc = 1'b0;                            to_inf = 1'b0;    end
      2'b10: begin inc = nx && sign_q;                    to_inf = sign_q;  end
      2'b11: begin inc = nx && !sign_q;                   to_inf = !sign_q; end
      default: ;
    endcase
    rnd_sum = {1'b0, sig_q} + {{M{1'b0}}, inc};
    if (rnd_sum[M]) begin
      rnd_sig = {1'b1, {(M-1){1'b0}}};
      rnd_exp = exp_q + E_ONE;
    end else begin
      rnd_sig = rnd_sum[M-1:0];
      rnd_exp = exp_q;
    end
    rnd_bexp = rnd_exp + BIAS;
    ovf      = rnd_exp > BIAS;
    uf       = tiny_q && nx;
    if (ovf) begin
      pack_z     = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      pack_flags = {1'b0, 1'b1, uf, 1'b1};
    end else begin
      // Hidden bit clear means a subnormal, packed with a zero exponent field.
      pack_z     = {sign_q, rnd_sig[M-1] ? rnd_bexp[EXP_W-1:0] : {EXP_W{1'b0}},
                    rnd_sig[M-2:0]};
      pack_flags = {1'b0, 1'b0, uf, nx};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StUnpack;
      StUnpack:  state_d = special ? StOut : StNorm;
      StNorm:    if (a_sig_q[M-1] && b_sig_q[M-1]) state_d = StMul;
      StMul:     if (cnt_q == MUL_LAST) state_d = StNormOut;
      StNormOut: state_d = StDenorm;
      StDenorm:  if (!den_go) state_d = StRound;
      StRound:   state_d = StOut;
      StOut:     if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; rm_q <= '0; sign_q <= 1'b0;
      a_e_q <= '0; b_e_q <= '0; exp_q <= '0;
      a_sig_q <= '0; b_sig_q <= '0; sig_q <= '0; prod_q <= '0;
      g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0; tiny_q <= 1'b0; cnt_q <= '0;
      out_z <= '0; out_flags <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q       <= in_a;
            b_q       <= in_b;
            rm_q      <= in_rm;
            out_flags <= '0;
          end
        end
        StUnpack: begin
          if (special) begin
            out_z     <= spec_z;
            out_flags <= spec_flags;
          end
          sign_q  <= sign_ab;
          a_e_q   <= a_e_un;
          b_e_q   <= b_e_un;
          a_sig_q <= {(a_ef != '0), a_fr};
          b_sig_q <= {(b_ef != '0), b_fr};
        end
        StNorm: begin
          // Normalise A first, then B, one bit per cycle.
          if (!a_sig_q[M-1]) begin
            a_sig_q <= {a_sig_q[M-2:0], 1'b0};
            a_e_q   <= a_e_q - E_ONE;
          end else if (!b_sig_q[M-1]) begin
            b_sig_q <= {b_sig_q[M-2:0], 1'b0};
            b_e_q   <= b_e_q - E_ONE;
          end
          prod_q <= '0;
          cnt_q  <= '0;
        end
        StMul: begin
          // Right-shifting accumulator: add A into the top half, then shift.
          prod_q  <= {mul_sum, prod_q[M-1:1]};
          b_sig_q <= {1'b0, b_sig_q[M-1:1]};
          exp_q   <= a_e_q + b_e_q;
          cnt_q   <= cnt_q + CNT_ONE;
        end
        StNormOut: begin
          exp_q  <= prod_q[2*M-1] ? exp_q + E_ONE : exp_q;
          sig_q  <= prod_sh[2*M-1 -: M];
          g_q    <= prod_sh[M-1];
          r_q    <= prod_sh[M-2];
          s_q    <= |prod_sh[M-3:0];
          tiny_q <= 1'b0;
          cnt_q  <= '0;
        end
        StDenorm: begin
          if (exp_q < EMIN) tiny_q <= 1'b1;
          if (den_go) begin
            sig_q <= {1'b0, sig_q[M-1:1]};
            g_q   <= sig_q[0];
            r_q   <= g_q;
            s_q   <= s_q | r_q;
            exp_q <= exp_q + E_ONE;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        StRound: begin
          out_z     <= pack_z;
          out_flags <= pack_flags;
        end
        StOut: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed bench for fp_mul_param at default single-precision parameters.
module tb_fp_mul_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_z;
  logic [3:0]  out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_flags (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for out_valid after an accept edge, counting cycles.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Issue one operation, take the result with out_ready high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        output logic [31:0] z, output logic [3:0] f, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    in_a = a; in_b = b; in_rm = rm; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    z = out_z;
    f = out_flags;
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] ez, input logic [3:0] ef,
                        input int elat);
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    run_op(a, b, rm, z, f, lat);
    check({tag, ".z"}, z, ez);
    check({tag, ".flags"}, {28'd0, f}, {28'd0, ef});
    check({tag, ".lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    int          lat;
    logic [31:0] hold_z;
    logic [3:0]  hold_f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_z", out_z, 32'h0);
    check("rst.out_flags", {28'd0, out_flags}, 32'd0);

    // flags are {NV, OF, UF, NX}
    do_vec("rne_basic",   32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 29);
    do_vec("inf_x_zero",  32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b1000, 1);
    do_vec("snan",        32'h7FA00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 1);
    do_vec("qnan",        32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000, 1);
    do_vec("inf_x_fin",   32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000, 1);
    do_vec("zero_x_fin",  32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000, 1);
    do_vec("ovf_rne",     32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101, 29);
    do_vec("ovf_rtz",     32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101, 29);
    do_vec("ovf_rdn",     32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F7FFFFF, 4'b0101, 29);
    do_vec("ovf_rup",     32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F800000, 4'b0101, 29);
    // 2^-149 * 0.5: 23 NORM shifts, 24 DENORM shifts -> 76 cycles
    do_vec("tie_rne",     32'h00000001, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011, 76);
    do_vec("tie_rup",     32'h00000001, 32'h3F000000, 2'b11, 32'h00000001, 4'b0011, 76);
    do_vec("tie_rdn_neg", 32'h80000001, 32'h3F000000, 2'b10, 32'h80000001, 4'b0011, 76);
    // (1+2^-23)^2 = 1 + 2^-22 + 2^-46: sticky only
    do_vec("nx_rne",      32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, 29);
    do_vec("nx_rup",      32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003, 4'b0001, 29);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h3FC00000; in_b = 32'h40000000; in_rm = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("bp.lat", 32'(lat), 32'd29);
    hold_z = out_z;
    hold_f = out_flags;
    check("bp.z", hold_z, 32'h40400000);
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_rm = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.hold_z", out_z, 32'h40400000);
      check("bp.hold_flags", {28'd0, out_flags}, 32'd0);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.drop_valid", {31'd0, out_valid}, 32'd0);
    check("bp.ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp.accepted", {31'd0, in_ready}, 32'd0);
    wait_result(lat);
    check("bp.next_lat", 32'(lat), 32'd29);
    check("bp.next_z", out_z, 32'h3F800000);
    @(posedge clk);
    #1;

    // Reset during MUL aborts the operation.
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_rm = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.out_z", out_z, 32'h0);
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    do_vec("after_rst", 32'h3F800000, 32'hC0000000, 2'b00, 32'hC0000000, 4'b0000, 29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
